// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator with a programmable int.frac divisor, oversample
// phase tracking, glitch-free divisor reload with a one-cycle acknowledge, and phase realignment.
module baud_gen_frac #(
    parameter int CNT_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_INT  = 325,
    parameter int DEFAULT_FRAC = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       div_int,
    input  logic [FRAC_W-1:0]      div_frac,
    input  logic                   div_load,
    output logic                   div_ack,
    input  logic                   phase_clr,
    output logic                   os_tick,
    output logic                   bit_tick,
    output logic [$clog2(OSR)-1:0] os_phase,
    output logic                   baud_clk
);
    localparam int PH_W = $clog2(OSR);
    localparam logic [CNT_W-1:0]  RST_INT  = (DEFAULT_INT < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(OSR / 2);

    // A divisor below 2 would leave no room for the one-cycle strobe to drop.
    function automatic logic [CNT_W-1:0] clamp_int(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [CNT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              ack_q, ack_d;
    logic              baud_q, baud_d;

    logic [CNT_W-1:0]  int_sel;
    logic [FRAC_W-1:0] frac_sel;
    logic [FRAC_W:0]   sum;
    logic              apply;

    always_comb begin
        int_sel     = pend_q ? pend_int_q : act_int_q;
        frac_sel    = pend_q ? pend_frac_q : act_frac_q;
        sum         = {1'b0, acc_q} + {1'b0, frac_sel};
        // Pending values take over at a period boundary, on realignment, or while frozen.
        apply       = pend_q && (phase_clr || !enable || (cnt_q == '0));

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q;
        phase_d     = phase_q;
        baud_d      = baud_q;
        os_tick_d   = 1'b0;
        bit_tick_d  = 1'b0;
        ack_d       = 1'b0;

        if (apply) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
        end
        if (div_load) begin
            pend_int_d  = clamp_int(div_int);
            pend_frac_d = div_frac;
            pend_d      = 1'b1;
        end

        if (phase_clr) begin
            cnt_d   = int_sel - CNT_W'(1);
            acc_d   = '0;
            phase_d = '0;
            baud_d  = 1'b1;
        end else if (enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                os_tick_d  = 1'b1;
                acc_d      = sum[FRAC_W-1:0];
                cnt_d      = int_sel - CNT_W'(1) + CNT_W'(sum[FRAC_W]);
                bit_tick_d = (phase_q == PH_LAST);
                phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                baud_d     = (phase_d < PH_HALF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= RST_INT - CNT_W'(1);
            acc_q       <= '0;
            act_int_q   <= RST_INT;
            act_frac_q  <= RST_FRAC;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            bit_tick_q  <= 1'b0;
            ack_q       <= 1'b0;
            baud_q      <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            phase_q     <= phase_d;
            os_tick_q   <= os_tick_d;
            bit_tick_q  <= bit_tick_d;
            ack_q       <= ack_d;
            baud_q      <= baud_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign div_ack  = ack_q;
    assign os_phase = phase_q;
    assign baud_clk = baud_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: an absolute-time tick model predicts each os_tick and
// div_ack edge; a negedge monitor pops and compares whenever the DUT strobes.
module tb_baud_gen_frac;
    localparam int CNT_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int OSR      = 16;
    localparam int DEF_INT  = 325;
    localparam int DEF_FRAC = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_load = 1'b0;
    logic              div_ack;
    logic              phase_clr = 1'b0;
    logic              os_tick;
    logic              bit_tick;
    logic [3:0]        os_phase;
    logic              baud_clk;

    baud_gen_frac #(
        .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR),
        .DEFAULT_INT(DEF_INT), .DEFAULT_FRAC(DEF_FRAC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .div_ack(div_ack), .phase_clr(phase_clr),
        .os_tick(os_tick), .bit_tick(bit_tick),
        .os_phase(os_phase), .baud_clk(baud_clk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int e;
        bit bt;
        int ph;
        bit bc;
    } tick_t;

    tick_t exp_tick[$];
    int    exp_ack[$];
    int    tick_log[$];

    // Reference model: ticks happen when the count of enabled edges since the last
    // realignment reaches an absolute target; each tick advances the target by int + carry.
    int m_int, m_frac, m_pint, m_pfrac, m_acc, m_ecount, m_target, m_ticks;
    bit m_pend;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_int    = (DEF_INT < 2) ? 2 : DEF_INT;
        m_frac   = DEF_FRAC;
        m_pend   = 0;
        m_pint   = 0;
        m_pfrac  = 0;
        m_acc    = 0;
        m_ecount = 0;
        m_target = m_int;
        m_ticks  = 0;
    endtask

    task automatic model_edge(input int e, input bit rst, input bit en, input bit clr,
                              input bit ld, input int di, input int df);
        int sel_int, sel_frac, s, ph;
        bit tick, carry;
        tick_t t;
        if (rst) begin
            model_reset();
        end else begin
            sel_int  = m_pend ? m_pint : m_int;
            sel_frac = m_pend ? m_pfrac : m_frac;
            tick = 0;
            if (clr) begin
                m_ecount = 0;
                m_target = sel_int;
                m_ticks  = 0;
                m_acc    = 0;
            end else if (en) begin
                m_ecount++;
                if (m_ecount == m_target) begin
                    tick  = 1;
                    s     = m_acc + sel_frac;
                    carry = (s >= (1 << FRAC_W));
                    m_acc = s % (1 << FRAC_W);
                    m_target += sel_int + (carry ? 1 : 0);
                    m_ticks++;
                    ph   = m_ticks % OSR;
                    t.e  = e;
                    t.bt = (ph == 0);
                    t.ph = ph;
                    t.bc = (ph < OSR / 2);
                    exp_tick.push_back(t);
                end
            end
            if (m_pend && (clr || !en || tick)) begin
                m_int  = m_pint;
                m_frac = m_pfrac;
                m_pend = 0;
                exp_ack.push_back(e);
            end
            if (ld) begin
                m_pint  = (di < 2) ? 2 : di;
                m_pfrac = df;
                m_pend  = 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit clr, input bit ld,
                        input int di = 0, input int df = 0);
        reset     = rst;
        enable    = en;
        phase_clr = clr;
        div_load  = ld;
        div_int   = CNT_W'(di);
        div_frac  = FRAC_W'(df);
        model_edge(cyc + 1, rst, en, clr, ld, di, df);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_os_tick", os_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_div_ack", div_ack, 0);
        chk("rst_os_phase", os_phase, 0);
        chk("rst_baud_clk", baud_clk, 1);
    endtask

    // Advance until the next enabled edge is predicted to be a tick edge.
    task automatic run_to_tick();
        for (int k = 0; k < 1000; k++) begin
            if (m_ecount + 1 == m_target) return;
            step(0, 1, 0, 0);
        end
        total++;
        bad++;
        $display("FAIL run_to_tick: no tick edge predicted within 1000 cycles");
    endtask

    always @(negedge clk) begin : monitor
        tick_t t;
        while (exp_tick.size() > 0 && exp_tick[0].e < cyc) begin
            total++;
            bad++;
            $display("FAIL tick_missing: got none, expected os_tick at edge %0d", exp_tick[0].e);
            void'(exp_tick.pop_front());
        end
        if (os_tick) begin
            tick_log.push_back(cyc);
            if (exp_tick.size() > 0 && exp_tick[0].e == cyc) begin
                t = exp_tick.pop_front();
                total++;
                chk("bit_tick", bit_tick, t.bt);
                chk("os_phase", os_phase, t.ph);
                chk("baud_clk", baud_clk, t.bc);
            end else begin
                total++;
                bad++;
                $display("FAIL tick_spurious: got os_tick at edge %0d, expected next at %0d",
                         cyc, (exp_tick.size() > 0) ? exp_tick[0].e : -1);
            end
        end else begin
            chk("bit_tick_alone", bit_tick, 0);
        end
        while (exp_ack.size() > 0 && exp_ack[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL ack_missing: got none, expected div_ack at edge %0d", exp_ack[0]);
            void'(exp_ack.pop_front());
        end
        if (div_ack) begin
            total++;
            if (exp_ack.size() > 0 && exp_ack[0] == cyc) begin
                void'(exp_ack.pop_front());
            end else begin
                bad++;
                $display("FAIL ack_spurious: got div_ack at edge %0d, expected next at %0d",
                         cyc, (exp_ack.size() > 0) ? exp_ack[0] : -1);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step(1, 0, 0, 0);
        check_reset_vals();

        // Defaults: 325/326 alternation, bit_tick every 16th tick, 32 spacings = 10416.
        tick_log.delete();
        run(33 * 326 + 50);
        chk("ticks_seen_ge_33", (tick_log.size() >= 33) ? 1 : 0, 1);
        chk("span_32_ticks", (tick_log.size() >= 33) ? tick_log[32] - tick_log[0] : -1, 10416);
        chk("first_tick_edge", (tick_log.size() > 0) ? tick_log[0] - 3 : -1, 325);

        // Mid-period load of 6: current period finishes, then spacing 6.
        run($urandom_range(1, 100));
        step(0, 1, 0, 1, 6, 0);
        run(400);

        // Two loads inside one period: single ack, spacing 8.
        run_to_tick();
        step(0, 1, 0, 0);
        step(0, 1, 0, 1, 6, 0);
        step(0, 1, 0, 1, 8, 0);
        run(60);

        // Load landing on the apply edge stays pending for the following boundary.
        step(0, 1, 0, 1, 5, 0);
        run_to_tick();
        step(0, 1, 0, 1, 7, 3);
        run(60);

        // phase_clr exactly on the cnt==0 edge suppresses that tick.
        run_to_tick();
        step(0, 1, 1, 0);
        chk("clr_os_tick", os_tick, 0);
        chk("clr_os_phase", os_phase, 0);
        chk("clr_baud_clk", baud_clk, 1);
        run(40);

        // Enable low mid-period freezes everything.
        run_to_tick();
        run($urandom_range(1, 4));
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        run(40);

        // div_int=0 clamps to 2; then reset mid-period and mid-load.
        step(0, 1, 0, 1, 0, 0);
        run(30);
        step(0, 1, 0, 1, 5, 0);
        step(1, 1, 0, 0);
        check_reset_vals();
        tick_log.delete();
        run(330);
        chk("post_reset_first_tick", (tick_log.size() > 0) ? tick_log[0] - (cyc - 330) : -1, 325);

        // Randomised mix of enable, realign, load and occasional reset.
        step(0, 1, 0, 1, 4, 0);
        run(340);
        for (int k = 0; k < 3000; k++) begin
            bit r, en, clr, ld;
            r   = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 24) == 0);
            step(r, en, clr, ld, $urandom_range(0, 9), $urandom_range(0, 15));
            if (r) check_reset_vals();
        end
        run(400);
        chk("tick_queue_drained", exp_tick.size(), 0);
        chk("ack_queue_drained", exp_ack.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised successor to the fixed-table baud generator. It is a fractional-N baud tick generator with a runtime-programmable fixed-point divisor and a configurable oversampling ratio. It produces a one-cycle oversample strobe, a bit strobe and a 50% duty baud clock for the UART TX/RX paths. Divisor changes are applied glitch-free at period boundaries and acknowledged by a handshake. A phase-clear input lets the receiver realign to a start bit.

Parameters:
CNT_W, 16, width of integer divisor and period counter
FRAC_W, 4, width of fractional divisor and phase accumulator (>=1)
OSR, 16, oversample ticks per bit (power of two, >=2)
DEFAULT_INT, 325, integer divisor after reset (50 MHz, 9600 baud x16)
DEFAULT_FRAC, 8, fractional divisor after reset (8/16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  count enable; low freezes all state
div_int  in  CNT_W  new integer divisor
div_frac  in  FRAC_W  new fractional divisor
div_load  in  1  one-cycle request to load div_int/div_frac
div_ack  out  1  one-cycle pulse: pending divisor became active
phase_clr  in  1  realign counters to start of bit
os_tick  out  1  one-cycle oversample strobe
bit_tick  out  1  one-cycle strobe on last os_tick of each bit
os_phase  out  log2(OSR)  oversample index within bit
baud_clk  out  1  high for os_phase 0..OSR/2-1, else low

Behaviour:
- Single clock domain; all outputs are registered; reset has the highest priority.
- Reset values:
  - active_int = max(DEFAULT_INT, 2), active_frac = DEFAULT_FRAC.
  - cnt = active_int-1, acc = 0, pending = 0, os_phase = 0.
  - os_tick = bit_tick = div_ack = 0, baud_clk = 1.
- Period counter, on each edge with enable=1 and no phase_clr:
  - If cnt != 0: cnt <= cnt-1, os_tick <= 0.
  - If cnt == 0: os_tick <= 1.
    - {carry, acc} <= acc + frac_sel, a (FRAC_W+1)-bit add.
    - cnt <= int_sel - 1 + carry.
    - int_sel/frac_sel = the pending values if pending, else the active values.
- Tick spacing is int + carry cycles, so the average period is int + frac/2^FRAC_W. First os_tick appears DEFAULT_INT enabled edges after reset is released.
- Divisor clamp: any applied div_int < 2 is clamped to 2.
- Load handshake:
  - div_load=1 captures div_int/div_frac into the pending registers and sets pending.
  - A second div_load while pending overwrites the pending values; only one ack results.
  - The pending values become active on the next os_tick edge (the reload above uses them).
  - If enable=0 at that time, they become active on the next edge instead.
  - div_ack pulses for exactly one cycle, registered together with the new active values; pending then clears.
  - div_load on the same edge as the apply: the new capture stays pending and no value is lost.
- Oversample phase, on each os_tick edge:
  - os_phase <= os_phase+1, wrapping at OSR-1 -> 0.
  - bit_tick <= 1 on the same edge os_tick is set, when the old os_phase == OSR-1; otherwise 0.
  - baud_clk <= (new os_phase < OSR/2).
- phase_clr, synchronous, over-rides tick generation on that edge:
  - cnt <= active_int-1, acc <= 0, os_phase <= 0, baud_clk <= 1, os_tick = bit_tick = 0.
  - A pending divisor is applied on this edge and acked.
- enable=0: cnt, acc and os_phase hold; os_tick = bit_tick = 0; baud_clk holds.
- reset asserted mid-period or mid-load discards the pending value; no div_ack is issued.

Test Plan:
1. Defaults (325, 8/16), enable=1 -> os_tick spacings 325, 326, 325, 326...; 32 ticks span 10416 cycles; bit_tick on every 16th os_tick; baud_clk high 8 ticks, low 8 ticks.
2. Override DEFAULT_INT=4, DEFAULT_FRAC=0, OSR=4; pulse div_load with div_int=6 mid-period -> current 4-cycle period completes; div_ack one cycle later; subsequent spacing 6.
3. Two div_load pulses (6, then 8) before the period ends -> single div_ack; spacing becomes 8.
4. phase_clr asserted in the same cycle cnt==0 -> no os_tick that cycle; os_phase=0; next os_tick after exactly active_int cycles.
5. enable low for 10 cycles mid-period -> no ticks; on re-enable the remaining count resumes unchanged (total spacing = period + 10).
6. div_load with div_int=0 -> applied as 2 (os_tick every 2 cycles); then assert reset mid-period -> all outputs at reset values next cycle and defaults restored.
